// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-memory request/acknowledge bus used by mem_stage.
//
// Handshake: the master raises dmem_req together with dmem_we, dmem_addr,
// dmem_be and dmem_wdata and holds all of them stable until the slave
// answers with a single-cycle dmem_ack strobe. dmem_rdata is only meaningful
// in the cycle dmem_ack is high. There is no back-pressure on the
// acknowledge.
//
// Signals:
//   dmem_req   master->slave  request pending
//   dmem_we    master->slave  1 = store, 0 = load
//   dmem_addr  master->slave  word-aligned byte address
//   dmem_be    master->slave  byte lane enables
//   dmem_wdata master->slave  lane-replicated store data
//   dmem_ack   slave->master  single-cycle completion strobe
//   dmem_rdata slave->master  read word, valid with dmem_ack
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- RV32I memory-access stage.
//
// Sits directly after ex_stage. Loads and stores with a legal funct3 and a
// naturally aligned address go out on the data-memory bus; everything else
// (ALU ops, jumps, branches, misaligned or illegal memory ops) retires into
// the MEM/WB registers one cycle after presentation. While a bus transaction
// is outstanding, stall holds ex_stage. A transaction that sees no ack within
// TIMEOUT_CYCLES bus cycles is abandoned and retired with bus_err.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   valid_in         ex_stage presents a valid instruction
//   opcode, funct3   instruction class and width
//   pc               instruction address (link value for JAL/JALR)
//   b                store data
//   c                ALU result / effective address
//   reg_wr_addr      destination register
//   stall            combinational hold request to ex_stage
//   dmem             data-memory bus (master side)
//   valid_out        MEM/WB holds a retired instruction
//   opcode_to_wb     retired opcode
//   wb_addr          retired destination register
//   wb_data          write-back data
//   wb_en            register-file write enable
//   misalign         retired op was misaligned or had an illegal funct3
//   bus_err          retired op timed out on the bus
//   state_dbg        FSM state: 0 = IDLE, 1 = BUS
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [31:0]       pc,
  input  logic [31:0]       b,
  input  logic [31:0]       c,
  input  logic [4:0]        reg_wr_addr,
  output logic              stall,
  mem_stage_if.master       dmem,
  output logic              valid_out,
  output logic [6:0]        opcode_to_wb,
  output logic [4:0]        wb_addr,
  output logic [31:0]       wb_data,
  output logic              wb_en,
  output logic              misalign,
  output logic              bus_err,
  output logic              state_dbg
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  // Decode of the presented instruction.
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        f3_legal;
  logic        unaligned;
  logic        bad_access;
  logic        go_mem;
  logic        writes_rd;
  logic        is_link;
  logic [3:0]  lane_be;
  logic [31:0] store_wdata;

  // Command latched at request time; used to retire the transaction.
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;
  logic [6:0]  op_q;
  logic        load_q;

  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_mem   = is_load | is_store;

    f3_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = is_mem;
      3'b100, 3'b101:         f3_legal = is_load;
      default:                f3_legal = 1'b0;
    endcase

    // funct3[1:0] encodes the access size for every legal encoding.
    unaligned  = ((funct3[1:0] == 2'b01) && c[0]) ||
                 ((funct3[1:0] == 2'b10) && (c[1:0] != 2'b00));
    bad_access = is_mem & (~f3_legal | unaligned);
    go_mem     = valid_in & is_mem & ~bad_access;

    lane_be = 4'b1111;
    case (funct3[1:0])
      2'b00:   lane_be = 4'b0001 << c[1:0];
      2'b01:   lane_be = c[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase

    store_wdata = 32'd0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00:   store_wdata = {4{b[7:0]}};
        2'b01:   store_wdata = {2{b[15:0]}};
        default: store_wdata = b;
      endcase
    end

    writes_rd = (opcode == OP_LUI)  || (opcode == OP_AUIPC) ||
                (opcode == OP_JAL)  || (opcode == OP_JALR)  ||
                (opcode == OP_LOAD) || (opcode == OP_IMM)   ||
                (opcode == OP_REG);
    is_link   = (opcode == OP_JAL) || (opcode == OP_JALR);
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rdata_shifted = dmem.dmem_rdata >> {lane_q, 3'b000};
    load_data     = dmem.dmem_rdata;
    case (f3_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  assign timeout_hit = (cnt == CNT_LAST);
  assign state_dbg   = (state == BUS);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and stall. The hold is released in the cycle the
  // transaction finishes (ack or timeout) so ex_stage advances on the same
  // edge that retires it. Stall is forced low while reset is asserted.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (go_mem) begin
          stall      = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        stall = ~dmem.dmem_ack & ~timeout_hit;
        if (dmem.dmem_ack || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) begin
      stall = 1'b0;
    end
  end

  // Bus drivers, latched command, timeout counter and MEM/WB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_be    <= 4'd0;
      dmem.dmem_wdata <= 32'd0;
      f3_q            <= 3'd0;
      lane_q          <= 2'd0;
      rd_q            <= 5'd0;
      op_q            <= 7'd0;
      load_q          <= 1'b0;
      valid_out       <= 1'b0;
      opcode_to_wb    <= 7'd0;
      wb_addr         <= 5'd0;
      wb_data         <= 32'd0;
      wb_en           <= 1'b0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (go_mem) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= is_store;
            dmem.dmem_addr  <= {c[31:2], 2'b00};
            dmem.dmem_be    <= lane_be;
            dmem.dmem_wdata <= store_wdata;
            f3_q            <= funct3;
            lane_q          <= c[1:0];
            rd_q            <= reg_wr_addr;
            op_q            <= opcode;
            load_q          <= is_load;
            valid_out       <= 1'b0;
            wb_en           <= 1'b0;
            misalign        <= 1'b0;
            bus_err         <= 1'b0;
          end else begin
            // Single-cycle retirement (or a bubble when valid_in is low).
            valid_out    <= valid_in;
            opcode_to_wb <= opcode;
            wb_addr      <= reg_wr_addr;
            wb_data      <= is_link ? (pc + 32'd4) : c;
            wb_en        <= valid_in & writes_rd & (reg_wr_addr != 5'd0) & ~bad_access;
            misalign     <= valid_in & bad_access;
            bus_err      <= 1'b0;
          end
        end
        BUS: begin
          if (dmem.dmem_ack) begin
            // Ack takes priority over a coincident timeout.
            dmem.dmem_req <= 1'b0;
            valid_out     <= 1'b1;
            opcode_to_wb  <= op_q;
            wb_addr       <= rd_q;
            wb_data       <= load_q ? load_data : 32'd0;
            wb_en         <= load_q & (rd_q != 5'd0);
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
          end else if (timeout_hit) begin
            dmem.dmem_req <= 1'b0;
            valid_out     <= 1'b1;
            opcode_to_wb  <= op_q;
            wb_addr       <= rd_q;
            wb_en         <= 1'b0;
            misalign      <= 1'b0;
            bus_err       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- RV32I memory-access stage, directly downstream of ex_stage. Consumes its outputs: opcode, funct3, pc, b (store data), c (ALU result/address), reg_wr_addr.
- Drives a req/ack data-memory bus for loads and stores, and performs load extraction with sign/zero extension and store lane steering.
- Registers the results into the MEM/WB pipeline boundary.
- Stalls upstream while a bus transaction is outstanding. Aborts a hung transaction after a timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of BUS-state cycles waiting for dmem_ack before abort. Must be ≥1.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  ex_stage outputs hold a valid instruction.
- opcode  input  7  opcode_to_mem from ex_stage.
- funct3  input  3  funct3_to_mem from ex_stage.
- pc  input  32  pc_to_mem from ex_stage.
- b  input  32  store data.
- c  input  32  ALU result; the effective address for loads and stores.
- reg_wr_addr  input  5  destination register.
- stall  output  1  upstream must hold all inputs stable while high (combinational).
- dmem_req  output  1  bus request (registered).
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  32  word-aligned address, {c[31:2],2'b00}.
- dmem_be  output  4  byte enables.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_ack  input  1  single-cycle completion strobe.
- dmem_rdata  input  32  read word; valid only when dmem_ack=1.
- valid_out  output  1  MEM/WB holds a retired instruction.
- opcode_to_wb  output  7  registered opcode.
- wb_addr  output  5  registered destination register.
- wb_data  output  32  registered write-back data.
- wb_en  output  1  register-file write enable.
- misalign  output  1  retired instruction was misaligned or had an illegal funct3.
- bus_err  output  1  retired instruction timed out on the bus.

Behaviour:
Reset (asynchronous, rst_n=0)
- State → IDLE. Timeout counter → 0.
- All registered outputs → 0, including dmem_req. Any in-flight transaction is dropped; a late ack after reset is ignored.

Operation classes
- MEM: opcode 0000011 (load) or 0100011 (store).
- All other opcodes retire in 1 cycle with no bus activity and stall=0.
- wb_data for non-MEM ops:
  - JAL (1101111) and JALR (1100111): pc+4 (mod 2^32).
  - Everything else: c.
- wb_en = valid, AND opcode ∈ {LUI, AUIPC, JAL, JALR, load, 0010011, 0110011}, AND reg_wr_addr≠0, AND no misalign, AND no bus_err.
- valid_in=0 → next valid_out=0 and wb_en=0; other wb fields don't-care.

Alignment and legality
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Store funct3: 000 SB, 001 SH, 010 SW.
- Halfword with c[0]=1, word with c[1:0]≠0, or any other funct3 → misaligned:
  - no bus request;
  - retires in 1 cycle with misalign=1, wb_en=0, stall=0.

Store steering
- SB: be = 4'b0001<<c[1:0]; wdata = {4{b[7:0]}}.
- SH: be = c[1] ? 4'b1100 : 4'b0011; wdata = {2{b[15:0]}}.
- SW: be = 4'b1111; wdata = b.
- For loads, dmem_be uses the same lane pattern and dmem_wdata = 0.

Load extraction
- Select the byte/half from dmem_rdata by c[1:0].
- LB/LH: sign-extend. LBU/LHU: zero-extend. LW: full word.

FSM (IDLE, BUS)
- IDLE, valid_in=1 and aligned MEM op:
  - stall=1 (combinational).
  - At the clock edge: latch command, dmem_req←1, counter←0, state←BUS, valid_out←0.
- BUS:
  - dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata held stable.
  - stall = ~dmem_ack & ~timeout_hit, where timeout_hit = (counter==TIMEOUT_CYCLES-1).
  - Counter increments each cycle without ack.
- BUS with dmem_ack=1:
  - At the edge: dmem_req←0, MEM/WB loaded (loads: extracted data, wb_en per rules; stores: wb_en=0), valid_out←1, state←IDLE.
- BUS with timeout_hit and no ack:
  - At the edge: dmem_req←0, valid_out←1, bus_err←1, wb_en←0, state←IDLE.
  - If ack and timeout_hit occur in the same cycle, ack wins.
- dmem_ack while in IDLE is ignored.

Latency
- Minimum MEM latency: 2 cycles (IDLE cycle plus ack on the first BUS cycle).
- Back-to-back MEM ops: one dead cycle between requests (dmem_req low for ≥1 cycle).
- misalign and bus_err are valid only alongside valid_out; they clear on the next retirement.

Test Plan:
- Reset mid-BUS: assert rst_n=0 while dmem_req=1 → dmem_req, valid_out, stall all 0 immediately. A later dmem_ack causes no retirement.
- LB, c=0x0000_0103, rdata=0x80FF_7F01, ack on first BUS cycle → dmem_addr=0x100, be=4'b1000, wb_data=0xFFFF_FF80, wb_en=1, stall high for exactly 1 cycle, valid_out 2 cycles after presentation. Repeat as LHU with c=0x102 → wb_data=0x0000_80FF.
- SH, c=0x0000_0006, b=0x1234_ABCD, ack after 3 wait cycles → dmem_we=1, be=4'b1100, wdata=0xABCD_ABCD, held stable during the wait; wb_en=0, valid_out=1 on ack.
- LW, c=0x0000_0002 → no dmem_req, misalign=1, wb_en=0, stall=0, 1-cycle retire.
- JAL, pc=4, c=8, rd=1 → wb_data=8 (pc+4), wb_en=1. Same with rd=0 → wb_en=0. Branch op (1100011) → wb_en=0.
- TIMEOUT_CYCLES=4, LW, no ack → dmem_req high exactly 4 cycles, then bus_err=1, valid_out=1, wb_en=0, stall drops in the 4th BUS cycle.
